// File: rtl/game_pkg.sv
// Shared constants for the raccoon game session logic: FSM state encoding,
// 7-segment codes and default sprite sizes.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WIN  = 2'b10,
    ST_OVER = 2'b11
  } game_state_t;

  // Active-low {G,F,E,D,C,B,A}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int unsigned DEF_PLAYER_W = 32;
  localparam int unsigned DEF_PLAYER_H = 32;
  localparam int unsigned DEF_CAR_W    = 32;
  localparam int unsigned DEF_CAR_H    = 32;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/game_session_ctrl_aabb_overlap.sv
// Combinational axis-aligned box overlap test between the raccoon and one car.
module aabb_overlap #(
  parameter int unsigned PLAYER_W = 32,
  parameter int unsigned PLAYER_H = 32,
  parameter int unsigned CAR_W    = 32,
  parameter int unsigned CAR_H    = 32
) (
  input  logic [9:0] rx,
  input  logic [9:0] ry,
  input  logic [9:0] cx,
  input  logic [9:0] cy,
  output logic       overlap
);

  // 11-bit edges so a box near x/y = 1023 never wraps to the left/top
  logic [10:0] r_left, r_top, r_right, r_bottom;
  logic [10:0] c_left, c_top, c_right, c_bottom;

  always_comb begin
    r_left   = {1'b0, rx};
    r_top    = {1'b0, ry};
    c_left   = {1'b0, cx};
    c_top    = {1'b0, cy};
    r_right  = r_left + 11'(PLAYER_W);
    r_bottom = r_top  + 11'(PLAYER_H);
    c_right  = c_left + 11'(CAR_W);
    c_bottom = c_top  + 11'(CAR_H);
    overlap  = (r_left < c_right) && (r_right > c_left) &&
               (r_top < c_bottom) && (r_bottom > c_top);
  end

endmodule

// File: rtl/game_session_ctrl.sv
// Session controller: game FSM, lives, level, hit debounce/invulnerability,
// and the level digit / lives LED display drive.
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int unsigned N_CARS       = 3,
  parameter int unsigned MAX_LIVES    = 3,
  parameter int unsigned WIN_LEVEL    = 9,
  parameter int unsigned INVUL_CYCLES = 25000000,
  parameter int unsigned PLAYER_W     = DEF_PLAYER_W,
  parameter int unsigned PLAYER_H     = DEF_PLAYER_H,
  parameter int unsigned CAR_W        = DEF_CAR_W,
  parameter int unsigned CAR_H        = DEF_CAR_H
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Start,
  input  logic                   i_Level_Up,
  input  logic [9:0]             i_Raccoon_X,
  input  logic [9:0]             i_Raccoon_Y,
  input  logic [10*N_CARS-1:0]   i_Car_X,
  input  logic [10*N_CARS-1:0]   i_Car_Y,
  output logic [1:0]             o_Game_State,
  output logic [3:0]             o_Level,
  output logic [2:0]             o_Lives,
  output logic [MAX_LIVES-1:0]   o_Lives_LED,
  output logic [6:0]             o_Segment,
  output logic                   o_Hit,
  output logic                   o_Respawn
);

  localparam int unsigned CW = (INVUL_CYCLES > 1) ? $clog2(INVUL_CYCLES) : 1;

  game_state_t       state;
  logic [N_CARS-1:0] lane_hit;
  logic              coll_q, coll_prev;
  logic [CW-1:0]     invul;
  logic              hit_event;
  logic [3:0]        next_level;

  for (genvar k = 0; k < N_CARS; k++) begin : g_lane
    aabb_overlap #(
      .PLAYER_W(PLAYER_W),
      .PLAYER_H(PLAYER_H),
      .CAR_W   (CAR_W),
      .CAR_H   (CAR_H)
    ) u_aabb (
      .rx     (i_Raccoon_X),
      .ry     (i_Raccoon_Y),
      .cx     (i_Car_X[10*k +: 10]),
      .cy     (i_Car_Y[10*k +: 10]),
      .overlap(lane_hit[k])
    );
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      coll_q    <= 1'b0;
      coll_prev <= 1'b0;
    end else begin
      coll_q    <= |lane_hit;
      coll_prev <= coll_q;
    end
  end

  // Only a fresh rising edge counts, so a car parked on the raccoon hits once
  assign hit_event  = coll_q && !coll_prev && (state == ST_RUN) && (invul == '0);
  assign next_level = o_Level + 4'd1;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state     <= ST_IDLE;
      o_Level   <= '0;
      o_Lives   <= 3'(MAX_LIVES);
      o_Hit     <= 1'b0;
      o_Respawn <= 1'b0;
      invul     <= '0;
    end else begin
      o_Hit     <= 1'b0;
      o_Respawn <= 1'b0;
      if (invul != '0) invul <= invul - 1'b1;
      case (state)
        ST_IDLE: begin
          if (i_Start) begin
            state   <= ST_RUN;
            o_Lives <= 3'(MAX_LIVES);
            o_Level <= '0;
            invul   <= '0;
          end
        end
        ST_RUN: begin
          if (hit_event) begin
            o_Hit     <= 1'b1;
            o_Respawn <= 1'b1;
            o_Lives   <= o_Lives - 3'd1;
            invul     <= CW'(INVUL_CYCLES - 1);
            if (o_Lives == 3'd1) state <= ST_OVER;
          end else if (i_Level_Up) begin
            o_Level   <= next_level;
            o_Respawn <= 1'b1;
            if (next_level == 4'(WIN_LEVEL)) state <= ST_WIN;
          end
        end
        ST_WIN, ST_OVER: begin
          if (!i_Start) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_Game_State = state;
  assign o_Segment    = seg_decode(o_Level);

  always_comb begin
    o_Lives_LED = '0;
    for (int unsigned i = 0; i < MAX_LIVES; i++)
      o_Lives_LED[i] = ({29'd0, o_Lives} > i);
  end

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed bench for game_session_ctrl with a short invulnerability window.
module tb_game_session_ctrl;

  localparam int unsigned N_CARS = 3;
  localparam int unsigned MAX_LIVES = 3;
  localparam int unsigned INVUL = 100;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 level_up;
  logic [9:0]           rx, ry;
  logic [10*N_CARS-1:0] car_x, car_y;
  logic [1:0]           game_state;
  logic [3:0]           level;
  logic [2:0]           lives;
  logic [MAX_LIVES-1:0] lives_led;
  logic [6:0]           segment;
  logic                 hit, respawn;

  int errors = 0;
  int checks = 0;

  game_session_ctrl #(
    .N_CARS      (N_CARS),
    .MAX_LIVES   (MAX_LIVES),
    .WIN_LEVEL   (9),
    .INVUL_CYCLES(INVUL),
    .PLAYER_W    (32),
    .PLAYER_H    (32),
    .CAR_W       (32),
    .CAR_H       (32)
  ) dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_Start     (start),
    .i_Level_Up  (level_up),
    .i_Raccoon_X (rx),
    .i_Raccoon_Y (ry),
    .i_Car_X     (car_x),
    .i_Car_Y     (car_y),
    .o_Game_State(game_state),
    .o_Level     (level),
    .o_Lives     (lives),
    .o_Lives_LED (lives_led),
    .o_Segment   (segment),
    .o_Hit       (hit),
    .o_Respawn   (respawn)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Cars far from the raccoon's default spot (100,400)
  task automatic park_cars;
    car_x = {3{10'd600}};
    car_y = {3{10'd0}};
    rx = 10'd100;
    ry = 10'd400;
  endtask

  task automatic set_car(input int k, input logic [9:0] x, input logic [9:0] y);
    car_x[10*k +: 10] = x;
    car_y[10*k +: 10] = y;
  endtask

  task automatic reset_pulse;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic start_session;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", game_state); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives: got %0d expected 3", lives); end
    checks++; if (hit !== 1'b0 || respawn !== 1'b0) begin errors++; $display("FAIL reset_pulses: got hit=%b respawn=%b expected 0 0", hit, respawn); end
    checks++; if (lives_led !== 3'b111) begin errors++; $display("FAIL reset_led: got %b expected 111", lives_led); end
    checks++; if (segment !== 7'b1000000) begin errors++; $display("FAIL reset_seg: got %b expected 1000000", segment); end
    rst = 1'b0;
    tick();
    checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL idle_hold: got %b expected 00", game_state); end
  endtask

  task automatic test_start;
    start_session();
    checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL start_state: got %b expected 01", game_state); end
    checks++; if (lives !== 3'd3 || level !== 4'd0) begin errors++; $display("FAIL start_vals: got lives=%0d level=%0d expected 3 0", lives, level); end
    checks++; if (lives_led !== 3'b111 || segment !== 7'b1000000) begin errors++; $display("FAIL start_disp: got led=%b seg=%b expected 111 1000000", lives_led, segment); end
  endtask

  task automatic test_single_hit;
    int hits = 0;
    int resp = 0;
    int first = 0;
    set_car(1, rx, ry);
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (n == 10) park_cars();
      if (hit) begin hits++; if (first == 0) first = n; end
      if (respawn) resp++;
    end
    checks++; if (hits !== 1) begin errors++; $display("FAIL single_hit_count: got %0d expected 1", hits); end
    checks++; if (first !== 2) begin errors++; $display("FAIL single_hit_latency: got %0d expected 2", first); end
    checks++; if (resp !== 1) begin errors++; $display("FAIL single_hit_respawn: got %0d expected 1", resp); end
    checks++; if (lives !== 3'd2 || lives_led !== 3'b011) begin errors++; $display("FAIL single_hit_lives: got lives=%0d led=%b expected 2 011", lives, lives_led); end
    repeat (110) tick();
  endtask

  task automatic test_invul_window;
    int hits = 0;
    // Second rising edge inside the window must be ignored
    set_car(0, rx, ry);
    repeat (3) tick();
    park_cars();
    repeat (5) tick();
    set_car(0, rx, ry);
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (hit) hits++;
    end
    park_cars();
    checks++; if (hits !== 0 || lives !== 3'd1) begin errors++; $display("FAIL invul_window: got hits=%0d lives=%0d expected 0 1", hits, lives); end
    repeat (110) tick();
  endtask

  task automatic test_game_over;
    int hits;
    reset_pulse();
    start_session();
    for (int h = 0; h < 3; h++) begin
      hits = 0;
      if (h == 2) start = 1'b1;
      set_car(0, rx, ry);
      for (int n = 1; n <= 4; n++) begin
        tick();
        if (hit) hits++;
      end
      park_cars();
      checks++; if (hits !== 1 || lives !== 3'(2 - h)) begin errors++; $display("FAIL over_hit%0d: got hits=%0d lives=%0d expected 1 %0d", h, hits, lives, 2 - h); end
      if (h < 2) repeat (105) tick();
    end
    checks++; if (game_state !== 2'b11 || lives_led !== 3'b000) begin errors++; $display("FAIL over_state: got state=%b led=%b expected 11 000", game_state, lives_led); end
    hits = 0;
    set_car(2, rx, ry);
    for (int n = 1; n <= 5; n++) begin
      tick();
      if (hit) hits++;
    end
    park_cars();
    checks++; if (game_state !== 2'b11 || hits !== 0 || lives !== 3'd0) begin errors++; $display("FAIL over_hold: got state=%b hits=%0d lives=%0d expected 11 0 0", game_state, hits, lives); end
    start = 1'b0;
    tick();
    checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL over_to_idle: got %b expected 00", game_state); end
    tick();
    checks++; if (game_state !== 2'b00 || lives !== 3'd0) begin errors++; $display("FAIL idle_after_over: got state=%b lives=%0d expected 00 0", game_state, lives); end
  endtask

  task automatic test_level_win;
    int resp = 0;
    reset_pulse();
    start_session();
    start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      level_up = 1'b1;
      tick();
      level_up = 1'b0;
      if (respawn) resp++;
      if (i == 0) begin
        checks++; if (level !== 4'd1 || segment !== 7'b1111001) begin errors++; $display("FAIL level_first: got level=%0d seg=%b expected 1 1111001", level, segment); end
      end
      tick();
      if (respawn) resp++;
    end
    checks++; if (level !== 4'd9 || game_state !== 2'b10) begin errors++; $display("FAIL win_state: got level=%0d state=%b expected 9 10", level, game_state); end
    checks++; if (segment !== 7'b0010000) begin errors++; $display("FAIL win_seg: got %b expected 0010000", segment); end
    checks++; if (resp !== 9) begin errors++; $display("FAIL win_respawns: got %0d expected 9", resp); end
    level_up = 1'b1;
    tick();
    level_up = 1'b0;
    checks++; if (level !== 4'd9 || respawn !== 1'b0 || game_state !== 2'b10) begin errors++; $display("FAIL win_ignore: got level=%0d respawn=%b state=%b expected 9 0 10", level, respawn, game_state); end
    start = 1'b0;
    tick();
    checks++; if (game_state !== 2'b00 || level !== 4'd9) begin errors++; $display("FAIL win_to_idle: got state=%b level=%0d expected 00 9", game_state, level); end
  endtask

  task automatic test_hit_and_level;
    reset_pulse();
    start_session();
    set_car(2, rx, ry);
    tick();
    level_up = 1'b1;
    tick();
    level_up = 1'b0;
    checks++; if (hit !== 1'b1 || respawn !== 1'b1) begin errors++; $display("FAIL both_pulses: got hit=%b respawn=%b expected 1 1", hit, respawn); end
    checks++; if (lives !== 3'd2 || level !== 4'd0) begin errors++; $display("FAIL both_vals: got lives=%0d level=%0d expected 2 0", lives, level); end
    tick();
    park_cars();
    checks++; if (hit !== 1'b0 || respawn !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL both_after: got hit=%b respawn=%b level=%0d expected 0 0 0", hit, respawn, level); end
  endtask

  task automatic test_no_wrap;
    logic [9:0] rxs [4] = '{10'd1000, 10'd5, 10'd300, 10'd1000};
    logic [9:0] cxs [4] = '{10'd5, 10'd1000, 10'd332, 10'd990};
    int exp_hits [4] = '{0, 0, 0, 1};
    int hits;
    reset_pulse();
    start_session();
    for (int s = 0; s < 4; s++) begin
      hits = 0;
      rx = rxs[s];
      ry = 10'd200;
      set_car(0, cxs[s], 10'd200);
      for (int n = 1; n <= 5; n++) begin
        tick();
        if (hit) hits++;
      end
      park_cars();
      checks++; if (hits !== exp_hits[s]) begin errors++; $display("FAIL wrap_case%0d: got hits=%0d expected %0d", s, hits, exp_hits[s]); end
      repeat (105) tick();
    end
    checks++; if (lives !== 3'd2) begin errors++; $display("FAIL wrap_lives: got %0d expected 2", lives); end
  endtask

  task automatic test_reset_mid_run;
    reset_pulse();
    start_session();
    repeat (2) begin
      level_up = 1'b1;
      tick();
      level_up = 1'b0;
      tick();
    end
    set_car(1, rx, ry);
    tick();
    tick();
    checks++; if (hit !== 1'b1 || level !== 4'd2) begin errors++; $display("FAIL midrun_pre: got hit=%b level=%0d expected 1 2", hit, level); end
    rst = 1'b1;
    #1;
    checks++; if (game_state !== 2'b00 || level !== 4'd0 || lives !== 3'd3) begin errors++; $display("FAIL midrun_regs: got state=%b level=%0d lives=%0d expected 00 0 3", game_state, level, lives); end
    checks++; if (hit !== 1'b0 || respawn !== 1'b0) begin errors++; $display("FAIL midrun_pulses: got hit=%b respawn=%b expected 0 0", hit, respawn); end
    checks++; if (lives_led !== 3'b111 || segment !== 7'b1000000) begin errors++; $display("FAIL midrun_disp: got led=%b seg=%b expected 111 1000000", lives_led, segment); end
    park_cars();
    #1;
    rst = 1'b0;
    tick();
    checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL midrun_after: got %b expected 00", game_state); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    level_up = 1'b0;
    park_cars();
    test_reset();
    test_start();
    test_single_hit();
    test_invul_window();
    test_game_over();
    test_level_win();
    test_hit_and_level();
    test_no_wrap();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
